// File: rtl/pe_sched_pkg.sv
// Shared definitions for the PE_Group pass scheduler.
//  - State encoding for the scheduler FSM (IDLE=0, LOAD_W=1, FEED=2, DRAIN=3, FIN=4).
//  - cnt_width(): width of a beat counter that must hold values 0..size inclusive.
package pe_sched_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_FEED   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_W = ST_LOAD_W,
    FEED   = ST_FEED,
    DRAIN  = ST_DRAIN,
    FIN    = ST_FIN
  } state_e;

  // A counter must reach 'size' itself (that value marks the phase as complete).
  function automatic int cnt_width(input int size);
    return (size < 1) ? 1 : $clog2(size + 1);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Saturating beat counter for one scheduler phase.
// Ports:
//  clk, aclr_n  clock / asynchronous active-low reset
//  clear        synchronous clear (phase entry); wins over inc
//  inc          one beat handshaked this cycle
//  count        beats counted so far in this phase (0..Size)
//  last         count has reached Size; further incs are ignored
module beat_counter
  import pe_sched_pkg::*;
#(
  parameter int Size = 4,
  parameter int CntW = cnt_width(Size)
) (
  input  logic            clk,
  input  logic            aclr_n,
  input  logic            clear,
  input  logic            inc,
  output logic [CntW-1:0] count,
  output logic            last
);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  assign last  = (count_q == CntW'(Size));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !last) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pe_group_sched.sv
// Pass scheduler in front of one PE_Group.
// Routes three source streams (W, I, O-in) and one sink stream onto the PE_Group ports,
// one phase at a time, counting beats per phase and repeating for cfg_passes passes.
// Ports:
//  clk, aclr_n                 clock / asynchronous active-low reset
//  cfg_start/passes/reuse_w    run request; config latched when start is taken in IDLE
//  cfg_abort                   synchronous abort from any non-IDLE state
//  busy, done, aborted         status (done/aborted are one-cycle pulses)
//  pass_idx                    current 0-based pass
//  src_W/I/O_*                 upstream sources (valid/data in, rdy out)
//  snk_*                       downstream result sink (valid/data out, rdy in)
//  W/I/O_DataIn*, O_DataOut*   PE_Group side of each stream
// Handshake: a beat transfers in a cycle where valid and rdy are both high. Valid never
// waits on rdy. Gates are combinational from registered state, so data is never delayed
// or modified; a closed gate forces both the PE-side valid and source-side rdy to 0.
module pe_group_sched
  import pe_sched_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int W_PEGroupSize = 4,
  parameter int I_PEGroupSize = 7,
  parameter int O_PEGroupSize = 4,
  parameter int PassWidth     = 8
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 cfg_start,
  input  logic [PassWidth-1:0] cfg_passes,
  input  logic                 cfg_reuse_w,
  input  logic                 cfg_abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [PassWidth-1:0] pass_idx,
  input  logic                 src_W_Valid,
  output logic                 src_W_Rdy,
  input  logic [DataWidth-1:0] src_W_Data,
  input  logic                 src_I_Valid,
  output logic                 src_I_Rdy,
  input  logic [DataWidth-1:0] src_I_Data,
  input  logic                 src_O_Valid,
  output logic                 src_O_Rdy,
  input  logic [DataWidth-1:0] src_O_Data,
  output logic                 snk_Valid,
  input  logic                 snk_Rdy,
  output logic [DataWidth-1:0] snk_Data,
  output logic                 W_DataInValid,
  input  logic                 W_DataInRdy,
  output logic [DataWidth-1:0] W_DataIn,
  output logic                 I_DataInValid,
  input  logic                 I_DataInRdy,
  output logic [DataWidth-1:0] I_DataIn,
  output logic                 O_DataInValid,
  input  logic                 O_DataInRdy,
  output logic [DataWidth-1:0] O_DataIn,
  input  logic                 O_DataOutValid,
  output logic                 O_DataOutRdy,
  input  logic [DataWidth-1:0] O_DataOut
);

  localparam int WCW = cnt_width(W_PEGroupSize);
  localparam int ICW = cnt_width(I_PEGroupSize);
  localparam int OCW = cnt_width(O_PEGroupSize);

  state_e               state_q, state_d;
  logic [PassWidth-1:0] passes_q, passes_d;
  logic [PassWidth-1:0] pass_idx_q, pass_idx_d;
  logic                 reuse_q, reuse_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic           abort_now;
  logic           gate_w, gate_i, gate_oi, gate_d;
  logic           w_fire, i_fire, oi_fire, d_fire;
  logic           w_last, i_last, oi_last, d_last;
  logic [WCW-1:0] w_cnt;
  logic [ICW-1:0] i_cnt;
  logic [OCW-1:0] oi_cnt, d_cnt;
  logic           w_hit, i_hit, oi_hit, d_hit;
  logic           clear_cnt;
  logic [PassWidth:0] pass_next_w;
  logic           pass_more;

  assign abort_now = cfg_abort && (state_q != IDLE);

  // Gating: a phase's stream is open only in its state, until its count is reached,
  // and never in an abort cycle (a beat there would otherwise be lost uncounted).
  assign gate_w  = (state_q == LOAD_W) && !w_last  && !abort_now;
  assign gate_i  = (state_q == FEED)   && !i_last  && !abort_now;
  assign gate_oi = (state_q == FEED)   && !oi_last && !abort_now;
  assign gate_d  = (state_q == DRAIN)  && !d_last  && !abort_now;

  assign W_DataInValid = gate_w  & src_W_Valid;
  assign src_W_Rdy     = gate_w  & W_DataInRdy;
  assign W_DataIn      = src_W_Data;
  assign I_DataInValid = gate_i  & src_I_Valid;
  assign src_I_Rdy     = gate_i  & I_DataInRdy;
  assign I_DataIn      = src_I_Data;
  assign O_DataInValid = gate_oi & src_O_Valid;
  assign src_O_Rdy     = gate_oi & O_DataInRdy;
  assign O_DataIn      = src_O_Data;
  assign snk_Valid     = gate_d  & O_DataOutValid;
  assign O_DataOutRdy  = gate_d  & snk_Rdy;
  assign snk_Data      = O_DataOut;

  // Beats are counted on the PE-side handshake only.
  assign w_fire  = W_DataInValid & W_DataInRdy;
  assign i_fire  = I_DataInValid & I_DataInRdy;
  assign oi_fire = O_DataInValid & O_DataInRdy;
  assign d_fire  = snk_Valid & snk_Rdy;

  // "hit" = the phase's count is reached by the end of this cycle.
  assign w_hit  = w_fire && (w_cnt == WCW'(W_PEGroupSize - 1));
  assign i_hit  = i_last  || (i_fire  && (i_cnt  == ICW'(I_PEGroupSize - 1)));
  assign oi_hit = oi_last || (oi_fire && (oi_cnt == OCW'(O_PEGroupSize - 1)));
  assign d_hit  = d_fire && (d_cnt == OCW'(O_PEGroupSize - 1));

  assign pass_next_w = {1'b0, pass_idx_q} + {{PassWidth{1'b0}}, 1'b1};
  assign pass_more   = pass_next_w < {1'b0, passes_q};

  // Every state change is a phase entry, so all counters restart from zero.
  assign clear_cnt = (state_d != state_q);

  beat_counter #(.Size(W_PEGroupSize)) u_cnt_w (
    .clk(clk), .aclr_n(aclr_n), .clear(clear_cnt), .inc(w_fire), .count(w_cnt), .last(w_last)
  );
  beat_counter #(.Size(I_PEGroupSize)) u_cnt_i (
    .clk(clk), .aclr_n(aclr_n), .clear(clear_cnt), .inc(i_fire), .count(i_cnt), .last(i_last)
  );
  beat_counter #(.Size(O_PEGroupSize)) u_cnt_oi (
    .clk(clk), .aclr_n(aclr_n), .clear(clear_cnt), .inc(oi_fire), .count(oi_cnt), .last(oi_last)
  );
  beat_counter #(.Size(O_PEGroupSize)) u_cnt_d (
    .clk(clk), .aclr_n(aclr_n), .clear(clear_cnt), .inc(d_fire), .count(d_cnt), .last(d_last)
  );

  always_comb begin
    state_d    = state_q;
    passes_d   = passes_q;
    pass_idx_d = pass_idx_q;
    reuse_d    = reuse_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    if (abort_now) begin
      state_d    = IDLE;
      pass_idx_d = '0;
      aborted_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            passes_d   = cfg_passes;
            reuse_d    = cfg_reuse_w;
            pass_idx_d = '0;
            if (cfg_passes != '0) begin
              state_d = LOAD_W;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (w_hit) state_d = FEED;
        end
        FEED: begin
          if (i_hit && oi_hit) state_d = DRAIN;
        end
        DRAIN: begin
          if (d_hit) begin
            if (pass_more) begin
              pass_idx_d = pass_next_w[PassWidth-1:0];
              state_d    = reuse_q ? FEED : LOAD_W;
            end else begin
              state_d = FIN;
              // done is high for exactly the FIN cycle
              done_d  = 1'b1;
            end
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= IDLE;
      passes_q   <= '0;
      pass_idx_q <= '0;
      reuse_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      passes_q   <= passes_d;
      pass_idx_q <= pass_idx_d;
      reuse_q    <= reuse_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign pass_idx = pass_idx_q;

endmodule

// File: tb/tb_pe_group_sched.sv
module tb_pe_group_sched;

  localparam logic [31:0] W_BASE = 32'h40A0_0000;  // 5.0
  localparam logic [31:0] I_BASE = 32'h41A0_0000;  // 20.0
  localparam logic [31:0] O_BASE = 32'h42C8_0000;  // 100.0
  localparam logic [31:0] R_BASE = 32'h3F80_0000;  // 1.0

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aclr_n = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_start, cfg_reuse_w, cfg_abort;
  logic [7:0]  cfg_passes;
  logic        busy, done, aborted;
  logic [7:0]  pass_idx;
  logic        src_W_Valid, src_W_Rdy, src_I_Valid, src_I_Rdy, src_O_Valid, src_O_Rdy;
  logic [31:0] src_W_Data, src_I_Data, src_O_Data;
  logic        snk_Valid, snk_Rdy;
  logic [31:0] snk_Data;
  logic        W_DataInValid, W_DataInRdy, I_DataInValid, I_DataInRdy;
  logic        O_DataInValid, O_DataInRdy, O_DataOutValid, O_DataOutRdy;
  logic [31:0] W_DataIn, I_DataIn, O_DataIn, O_DataOut;

  pe_group_sched dut (
    .clk(clk), .aclr_n(aclr_n),
    .cfg_start(cfg_start), .cfg_passes(cfg_passes), .cfg_reuse_w(cfg_reuse_w), .cfg_abort(cfg_abort),
    .busy(busy), .done(done), .aborted(aborted), .pass_idx(pass_idx),
    .src_W_Valid(src_W_Valid), .src_W_Rdy(src_W_Rdy), .src_W_Data(src_W_Data),
    .src_I_Valid(src_I_Valid), .src_I_Rdy(src_I_Rdy), .src_I_Data(src_I_Data),
    .src_O_Valid(src_O_Valid), .src_O_Rdy(src_O_Rdy), .src_O_Data(src_O_Data),
    .snk_Valid(snk_Valid), .snk_Rdy(snk_Rdy), .snk_Data(snk_Data),
    .W_DataInValid(W_DataInValid), .W_DataInRdy(W_DataInRdy), .W_DataIn(W_DataIn),
    .I_DataInValid(I_DataInValid), .I_DataInRdy(I_DataInRdy), .I_DataIn(I_DataIn),
    .O_DataInValid(O_DataInValid), .O_DataInRdy(O_DataInRdy), .O_DataIn(O_DataIn),
    .O_DataOutValid(O_DataOutValid), .O_DataOutRdy(O_DataOutRdy), .O_DataOut(O_DataOut)
  );

  // ---------------- scoreboard / monitor ----------------
  // Cumulative statistics; each test compares the delta over its own run.
  typedef struct {
    int w; int i; int oi; int o;
    int busy; int done; int abrt; int derr; int steps; int last_pidx;
  } stats_t;

  stats_t st = '{default: 0};
  int sent_w = 0, sent_i = 0, sent_o = 0, sent_r = 0;
  logic fw, fi, foi, fd, fsw, fsi, fso, fr, rst_ok;
  logic [7:0] prev_pidx = 8'd0;

  always begin
    @(negedge clk);
    fw  = W_DataInValid && W_DataInRdy;
    fi  = I_DataInValid && I_DataInRdy;
    foi = O_DataInValid && O_DataInRdy;
    fd  = snk_Valid && snk_Rdy;
    fsw = src_W_Valid && src_W_Rdy;
    fsi = src_I_Valid && src_I_Rdy;
    fso = src_O_Valid && src_O_Rdy;
    fr  = O_DataOutValid && O_DataOutRdy;
    // In-order, no loss/duplication: the n-th PE-side beat must carry base+n.
    if (fw  && W_DataIn !== W_BASE + 32'(st.w))  st.derr++;
    if (fi  && I_DataIn !== I_BASE + 32'(st.i))  st.derr++;
    if (foi && O_DataIn !== O_BASE + 32'(st.oi)) st.derr++;
    if (fd  && snk_Data !== R_BASE + 32'(st.o))  st.derr++;
    if (busy) st.busy++;
    if (done) begin st.done++; st.last_pidx = int'(pass_idx); end
    if (aborted) st.abrt++;
    if (busy && pass_idx == prev_pidx + 8'd1) st.steps++;
    prev_pidx = pass_idx;
    @(posedge clk);
    rst_ok = aclr_n;
    #1;
    if (rst_ok) begin
      if (fw)  st.w++;
      if (fi)  st.i++;
      if (foi) st.oi++;
      if (fd)  st.o++;
      if (fsw) sent_w++;
      if (fsi) sent_i++;
      if (fso) sent_o++;
      if (fr)  sent_r++;
    end
    src_W_Data = W_BASE + 32'(sent_w);
    src_I_Data = I_BASE + 32'(sent_i);
    src_O_Data = O_BASE + 32'(sent_o);
    O_DataOut  = R_BASE + 32'(sent_r);
  end

  // ---------------- ready drivers (backpressure) ----------------
  logic i_toggle = 1'b0;
  int   stall_req = 0;
  int   stall_ack = 0;
  int   stall_left = 0;

  always begin
    @(posedge clk);
    #1;
    if (stall_ack != stall_req && snk_Valid) begin
      stall_left = 10;
      stall_ack  = stall_req;
    end
    snk_Rdy = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    I_DataInRdy = i_toggle ? ~I_DataInRdy : 1'b1;
  end

  // ---------------- check helpers ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_pulse(input logic [7:0] passes, input logic reuse);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_passes = passes; cfg_reuse_w = reuse;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input stats_t s0, input int budget);
    int n;
    n = 0;
    while (st.done == s0.done && st.abrt == s0.abrt && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk({tag, "_timeout"}, int'(n >= budget), 0);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic check_counts(input string tag, input stats_t s0,
                              input int w, input int i, input int oi, input int o,
                              input int dn, input int ab);
    chk({tag, "_w"},    st.w - s0.w, w);
    chk({tag, "_i"},    st.i - s0.i, i);
    chk({tag, "_oi"},   st.oi - s0.oi, oi);
    chk({tag, "_out"},  st.o - s0.o, o);
    chk({tag, "_done"}, st.done - s0.done, dn);
    chk({tag, "_abrt"}, st.abrt - s0.abrt, ab);
    chk({tag, "_data"}, st.derr - s0.derr, 0);
  endtask

  function automatic int out_bits();
    return int'({W_DataInValid, src_W_Rdy, I_DataInValid, src_I_Rdy, O_DataInValid, src_O_Rdy,
                 snk_Valid, O_DataOutRdy, busy, done, aborted});
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] passes;
    logic       reuse;
    int w; int i; int oi; int o; int busy; int pidx; int steps;
  } vec_t;

  vec_t vecs[5];

  initial begin
    stats_t s0;
    int     n;
    vecs[0] = '{8'd1, 1'b0,  4,  7,  4,  4, 16, 0, 0};
    vecs[1] = '{8'd3, 1'b1,  4, 21, 12, 12, 38, 2, 2};
    vecs[2] = '{8'd2, 1'b0,  8, 14,  8,  8, 31, 1, 1};
    vecs[3] = '{8'd0, 1'b0,  0,  0,  0,  0,  0, 0, 0};
    vecs[4] = '{8'd2, 1'b1,  4, 14,  8,  8, 27, 1, 1};

    cfg_start = 1'b0; cfg_passes = 8'd0; cfg_reuse_w = 1'b0; cfg_abort = 1'b0;
    src_W_Valid = 1'b1; src_I_Valid = 1'b1; src_O_Valid = 1'b1; O_DataOutValid = 1'b1;
    W_DataInRdy = 1'b1; O_DataInRdy = 1'b1;

    // Reset: all handshake/status outputs low even with every source valid.
    #3;
    chk("reset_outs", out_bits(), 0);
    chk("reset_pidx", int'(pass_idx), 0);
    repeat (3) @(negedge clk);
    aclr_n = 1'b1;
    @(negedge clk); #2;
    chk("idle_outs", out_bits(), 0);

    // Table: full runs with every stream always valid/ready.
    for (int k = 0; k < 5; k++) begin
      s0 = st;
      start_pulse(vecs[k].passes, vecs[k].reuse);
      wait_end($sformatf("vec%0d", k), s0, 400);
      check_counts($sformatf("vec%0d", k), s0, vecs[k].w, vecs[k].i, vecs[k].oi, vecs[k].o, 1, 0);
      chk($sformatf("vec%0d_busy", k),  st.busy - s0.busy, vecs[k].busy);
      chk($sformatf("vec%0d_pidx", k),  st.last_pidx, vecs[k].pidx);
      chk($sformatf("vec%0d_steps", k), st.steps - s0.steps, vecs[k].steps);
    end

    // passes==0: done exactly one cycle after start, busy never set.
    s0 = st;
    start_pulse(8'd0, 1'b0);
    @(negedge clk); #2;
    chk("p0_done_hi", int'(done), 1);
    chk("p0_busy", int'(busy), 0);
    @(negedge clk); #2;
    chk("p0_done_lo", int'(done), 0);
    chk("p0_busy_cnt", st.busy - s0.busy, 0);

    // Backpressure: I ready toggles, sink stalls 10 cycles at first DRAIN.
    s0 = st;
    i_toggle = 1'b1;
    stall_req++;
    start_pulse(8'd2, 1'b0);
    wait_end("bp", s0, 600);
    check_counts("bp", s0, 8, 14, 8, 8, 1, 0);
    chk("bp_stalled", int'((st.busy - s0.busy) >= 41), 1);
    i_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // Start (with different config) during FEED is ignored; latched config is used.
    s0 = st;
    start_pulse(8'd1, 1'b0);
    n = 0;
    while (st.i - s0.i < 2 && n < 40) begin @(posedge clk); #2; n++; end
    chk("sif_reach_feed", int'(n < 40), 1);
    cfg_start = 1'b1; cfg_passes = 8'd5; cfg_reuse_w = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    wait_end("sif", s0, 400);
    check_counts("sif", s0, 4, 7, 4, 4, 1, 0);
    chk("sif_busy", st.busy - s0.busy, 16);

    // Abort during the 3rd FEED beat.
    s0 = st;
    start_pulse(8'd2, 1'b0);
    n = 0;
    while (st.i - s0.i < 2 && n < 40) begin @(posedge clk); #2; n++; end
    chk("ab_reach_feed", int'(n < 40), 1);
    cfg_abort = 1'b1;
    #1;
    chk("ab_gate_i", int'({I_DataInValid, src_I_Rdy, O_DataInValid, src_O_Rdy}), 0);
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    @(negedge clk); #2;
    chk("ab_pulse", int'(aborted), 1);
    chk("ab_busy", int'(busy), 0);
    chk("ab_nodone", int'(done), 0);
    @(negedge clk); #2;
    chk("ab_pulse_end", int'(aborted), 0);
    check_counts("ab", s0, 4, 2, 2, 0, 0, 1);
    s0 = st;
    start_pulse(8'd1, 1'b0);
    wait_end("ab_rerun", s0, 400);
    check_counts("ab_rerun", s0, 4, 7, 4, 4, 1, 0);
    chk("ab_rerun_busy", st.busy - s0.busy, 16);

    // Asynchronous reset during DRAIN, then a clean run.
    s0 = st;
    start_pulse(8'd1, 1'b0);
    n = 0;
    while (st.o - s0.o < 2 && n < 60) begin @(posedge clk); #2; n++; end
    chk("rst_reach_drain", int'(n < 60), 1);
    #1;
    aclr_n = 1'b0;
    #1;
    chk("rst_async_outs", out_bits(), 0);
    chk("rst_async_pidx", int'(pass_idx), 0);
    repeat (2) @(negedge clk);
    aclr_n = 1'b1;
    chk("rst_nodone", st.done - s0.done, 0);
    s0 = st;
    start_pulse(8'd1, 1'b0);
    wait_end("rst_rerun", s0, 400);
    check_counts("rst_rerun", s0, 4, 7, 4, 4, 1, 0);
    chk("rst_rerun_busy", st.busy - s0.busy, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
